// File: rtl/int_controller_pkg.sv
// Shared definitions for the jacaranda-8 interrupt controller: default register
// addresses, FSM state encoding, CTRL bit layout and the vector address helper.
`default_nettype none

package int_controller_pkg;

  localparam logic [7:0] VBASE_ADDR_DEF = 8'd245;
  localparam logic [7:0] CTRL_ADDR_DEF  = 8'd246;
  localparam logic [7:0] PEND_ADDR_DEF  = 8'd247;
  localparam logic [7:0] MASK_ADDR_DEF  = 8'd248;

  localparam int CTRL_GEN_BIT  = 0;
  localparam int CTRL_IDX_LSB  = 3;
  localparam int CTRL_BUSY_BIT = 7;

  localparam logic [7:0] INT_EN_ON  = 8'h01;
  localparam logic [7:0] INT_EN_OFF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Handler address wraps modulo 256 on the 8-bit address space.
  function automatic logic [7:0] vec_addr(input logic [7:0] base,
                                          input logic [2:0] idx,
                                          input int         shift);
    return base + (8'(idx) << shift);
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: index 0 has the highest priority.
`default_nettype none

module int_prio_enc #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] active_i,
  output logic             valid_o,
  output logic [2:0]       sel_o
);

  always_comb begin
    valid_o = |active_i;
    sel_o   = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active_i[i]) sel_o = 3'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_controller.sv
// Multi-source interrupt controller: edge-latched pending bits, mask, fixed
// priority selection and a REQ/SERVICE handshake with the cpu.
`default_nettype none

module int_controller
  import int_controller_pkg::*;
#(
  parameter int         N_SRC      = 4,
  parameter int         VEC_SHIFT  = 2,
  parameter logic [7:0] VBASE_ADDR = VBASE_ADDR_DEF,
  parameter logic [7:0] CTRL_ADDR  = CTRL_ADDR_DEF,
  parameter logic [7:0] PEND_ADDR  = PEND_ADDR_DEF,
  parameter logic [7:0] MASK_ADDR  = MASK_ADDR_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [7:0]       bus_addr,
  input  logic [7:0]       bus_w_data,
  input  logic             bus_w_en,
  output logic [7:0]       bus_r_data,
  output logic             bus_hit,
  input  logic             cpu_int_ack,
  input  logic             cpu_int_ret,
  output logic             int_req,
  output logic [7:0]       int_vec,
  output logic [7:0]       int_en
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

  logic [N_SRC-1:0] prev_src_q;
  logic [7:0]       mask_q;
  logic [7:0]       pend_q;
  logic [7:0]       pend_d;
  logic [7:0]       vbase_q;
  logic             gen_q;
  state_e           state_q;
  logic [2:0]       svc_idx_q;
  logic             int_req_q;
  logic [7:0]       int_vec_q;
  logic [7:0]       int_en_q;

  logic [7:0] rise;
  logic [7:0] active;
  logic [7:0] ctrl_rd;
  logic       enc_valid;
  logic [2:0] enc_sel;
  logic       wr_vbase;
  logic       wr_ctrl;
  logic       wr_pend;
  logic       wr_mask;
  logic       ack_clr;

  assign wr_vbase = bus_w_en && (bus_addr == VBASE_ADDR);
  assign wr_ctrl  = bus_w_en && (bus_addr == CTRL_ADDR);
  assign wr_pend  = bus_w_en && (bus_addr == PEND_ADDR);
  assign wr_mask  = bus_w_en && (bus_addr == MASK_ADDR);
  assign ack_clr  = (state_q == ST_REQ) && cpu_int_ack;
  assign active   = pend_q & mask_q;

  always_comb begin
    rise               = 8'h00;
    rise[N_SRC-1:0]    = src_irq & ~prev_src_q;
  end

  // Clears are applied first so that a same-cycle edge always survives them.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~bus_w_data;
    if (ack_clr) pend_d[svc_idx_q] = 1'b0;
    pend_d = (pend_d | rise) & SRC_MASK;
  end

  int_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .active_i (active[N_SRC-1:0]),
    .valid_o  (enc_valid),
    .sel_o    (enc_sel)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_src_q <= '0;
      pend_q     <= 8'h00;
      mask_q     <= 8'h00;
      vbase_q    <= 8'h00;
      gen_q      <= 1'b0;
    end else begin
      prev_src_q <= src_irq;
      pend_q     <= pend_d;
      if (wr_mask)  mask_q  <= bus_w_data & SRC_MASK;
      if (wr_vbase) vbase_q <= bus_w_data;
      if (wr_ctrl)  gen_q   <= bus_w_data[CTRL_GEN_BIT];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      svc_idx_q <= 3'd0;
      int_req_q <= 1'b0;
      int_vec_q <= 8'h00;
      int_en_q  <= INT_EN_ON;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gen_q && enc_valid) begin
            state_q   <= ST_REQ;
            svc_idx_q <= enc_sel;
            int_vec_q <= vec_addr(vbase_q, enc_sel, VEC_SHIFT);
            int_req_q <= 1'b1;
            int_en_q  <= INT_EN_OFF;
          end
        end
        ST_REQ: begin
          // The latched source is kept until ack or withdrawal; no re-selection.
          if (cpu_int_ack) begin
            state_q   <= ST_SERVICE;
            int_req_q <= 1'b0;
          end else if (!gen_q || !active[svc_idx_q]) begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
            int_en_q  <= INT_EN_ON;
          end
        end
        ST_SERVICE: begin
          if (cpu_int_ret) begin
            state_q  <= ST_IDLE;
            int_en_q <= INT_EN_ON;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          int_req_q <= 1'b0;
          int_en_q  <= INT_EN_ON;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_rd                          = 8'h00;
    ctrl_rd[CTRL_BUSY_BIT]           = (state_q != ST_IDLE);
    ctrl_rd[CTRL_IDX_LSB +: 3]       = svc_idx_q;
    ctrl_rd[CTRL_GEN_BIT]            = gen_q;
  end

  always_comb begin
    bus_hit    = 1'b1;
    bus_r_data = 8'h00;
    if (bus_addr == VBASE_ADDR)      bus_r_data = vbase_q;
    else if (bus_addr == CTRL_ADDR)  bus_r_data = ctrl_rd;
    else if (bus_addr == PEND_ADDR)  bus_r_data = pend_q;
    else if (bus_addr == MASK_ADDR)  bus_r_data = mask_q;
    else                             bus_hit    = 1'b0;
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;
  assign int_en  = int_en_q;

endmodule

`default_nettype wire

// File: tb/tb_int_controller.sv
// Directed bench for int_controller with hand-computed expectations.
`default_nettype none

module tb_int_controller;

  localparam logic [7:0] A_VBASE = 8'd245;
  localparam logic [7:0] A_CTRL  = 8'd246;
  localparam logic [7:0] A_PEND  = 8'd247;
  localparam logic [7:0] A_MASK  = 8'd248;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] src_irq;
  logic [7:0] bus_addr;
  logic [7:0] bus_w_data;
  logic       bus_w_en;
  logic [7:0] bus_r_data;
  logic       bus_hit;
  logic       cpu_int_ack;
  logic       cpu_int_ret;
  logic       int_req;
  logic [7:0] int_vec;
  logic [7:0] int_en;

  int errors = 0;
  int checks = 0;

  int_controller dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .src_irq     (src_irq),
    .bus_addr    (bus_addr),
    .bus_w_data  (bus_w_data),
    .bus_w_en    (bus_w_en),
    .bus_r_data  (bus_r_data),
    .bus_hit     (bus_hit),
    .cpu_int_ack (cpu_int_ack),
    .cpu_int_ret (cpu_int_ret),
    .int_req     (int_req),
    .int_vec     (int_vec),
    .int_en      (int_en)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus_addr   = addr;
    bus_w_data = data;
    bus_w_en   = 1'b1;
    tick();
    bus_w_en   = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus_addr = addr;
    #1;
    chk(tag, bus_r_data, exp);
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [7:0] vec,
                         input logic [7:0] en);
    chk({tag, "_req"}, {7'b0, int_req}, {7'b0, req});
    chk({tag, "_vec"}, int_vec, vec);
    chk({tag, "_en"},  int_en,  en);
  endtask

  task automatic pulse_ack();
    cpu_int_ack = 1'b1;
    tick();
    cpu_int_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    cpu_int_ret = 1'b1;
    tick();
    cpu_int_ret = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    reset_n = 1'b0; src_irq = 4'h0; bus_addr = 8'h00; bus_w_data = 8'h00;
    bus_w_en = 1'b0; cpu_int_ack = 1'b0; cpu_int_ret = 1'b0;
    repeat (2) tick();

    // Reset state
    chk_out("rst", 1'b0, 8'h00, 8'h01);
    rdchk("rst_ctrl", A_CTRL, 8'h00);
    chk("rst_hit", {7'b0, bus_hit}, 8'h01);
    bus_addr = 8'h10; #1;
    chk("nohit_data", bus_r_data, 8'h00);
    chk("nohit_hit", {7'b0, bus_hit}, 8'h00);
    reset_n = 1'b1;
    tick();

    // 1: single source, two-edge latency, ack clears pending
    wr(A_MASK, 8'h01);
    wr(A_CTRL, 8'h01);
    wr(A_VBASE, 8'h40);
    rdchk("t1_mask", A_MASK, 8'h01);
    src_irq = 4'b0001;
    tick();
    rdchk("t1_pend_set", A_PEND, 8'h01);
    chk("t1_req_e0", {7'b0, int_req}, 8'h00);
    src_irq = 4'b0000;
    tick();
    chk_out("t1_req", 1'b1, 8'h40, 8'h00);
    rdchk("t1_ctrl_busy", A_CTRL, 8'h81);
    pulse_ack();
    chk_out("t1_svc", 1'b0, 8'h40, 8'h00);
    rdchk("t1_pend_clr", A_PEND, 8'h00);
    pulse_ret();
    chk_out("t1_idle", 1'b0, 8'h40, 8'h01);
    rdchk("t1_ctrl_idle", A_CTRL, 8'h01);

    // 2: simultaneous src1/src3, src1 first then src3
    wr(A_MASK, 8'h0F);
    src_irq = 4'b1010;
    tick();
    src_irq = 4'b0000;
    tick();
    chk_out("t2_first", 1'b1, 8'h44, 8'h00);
    rdchk("t2_ctrl", A_CTRL, 8'h89);
    pulse_ack();
    rdchk("t2_pend", A_PEND, 8'h08);
    pulse_ret();
    chk_out("t2_gap", 1'b0, 8'h44, 8'h01);
    tick();
    chk_out("t2_second", 1'b1, 8'h4C, 8'h00);
    pulse_ack();
    pulse_ret();

    // 3: masking while in REQ withdraws the request, pending kept
    src_irq = 4'b0100;
    tick();
    src_irq = 4'b0000;
    tick();
    chk_out("t3_req", 1'b1, 8'h48, 8'h00);
    wr(A_MASK, 8'h00);
    chk("t3_req_hold", {7'b0, int_req}, 8'h01);
    tick();
    chk_out("t3_drop", 1'b0, 8'h48, 8'h01);
    bus_addr = A_CTRL; #1; v = bus_r_data;
    chk("t3_busy", {7'b0, v[7]}, 8'h00);
    rdchk("t3_pend", A_PEND, 8'h04);

    // 4: set beats W1C; vector wraps modulo 256
    wr(A_PEND, 8'h04);
    rdchk("t4_w1c", A_PEND, 8'h00);
    src_irq    = 4'b0001;
    bus_addr   = A_PEND;
    bus_w_data = 8'h01;
    bus_w_en   = 1'b1;
    tick();
    bus_w_en   = 1'b0;
    src_irq    = 4'b0000;
    rdchk("t4_setwins", A_PEND, 8'h01);
    wr(A_PEND, 8'h01);
    wr(A_VBASE, 8'hFC);
    wr(A_MASK, 8'h02);
    src_irq = 4'b0010;
    tick();
    src_irq = 4'b0000;
    tick();
    chk_out("t4_wrap", 1'b1, 8'h00, 8'h00);
    pulse_ack();
    pulse_ret();

    // 5: re-fire during SERVICE waits for ret plus one IDLE cycle
    wr(A_VBASE, 8'h40);
    wr(A_MASK, 8'h01);
    src_irq = 4'b0001;
    tick();
    src_irq = 4'b0000;
    tick();
    pulse_ack();
    src_irq = 4'b0001;
    tick();
    src_irq = 4'b0000;
    chk("t5_no_req", {7'b0, int_req}, 8'h00);
    rdchk("t5_pend", A_PEND, 8'h01);
    tick();
    chk("t5_still_no_req", {7'b0, int_req}, 8'h00);
    pulse_ret();
    chk_out("t5_idle", 1'b0, 8'h40, 8'h01);
    tick();
    chk_out("t5_rereq", 1'b1, 8'h40, 8'h00);

    // 6: async reset in SERVICE without a clock edge
    pulse_ack();
    #1;
    reset_n = 1'b0;
    #1;
    chk_out("t6_rst", 1'b0, 8'h00, 8'h01);
    rdchk("t6_ctrl", A_CTRL, 8'h00);
    rdchk("t6_mask", A_MASK, 8'h00);
    rdchk("t6_vbase", A_VBASE, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
